seq_mag_cmp: RTL and testbench
==============================

Name: seq_mag_cmp

Overview:
Parametrised, registered magnitude comparator that generalises the team's 3-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, with early termination.
- Supports unsigned and two's-complement modes.
- Uses a start/busy/done handshake, so it can sit on a datapath bus without a wide single-cycle compare tree.
- Results hold in registers until the next operation.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of CHUNK, minimum 2.
CHUNK, 2, bits compared per cycle; 1..WIDTH.
NCH, WIDTH/CHUNK (derived localparam), number of chunks, i.e. maximum compare cycles.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled on clk rising edge
signed_mode  in  1  1 = two's-complement compare; captured with start
a  in  WIDTH  operand A; captured with start
b  in  WIDTH  operand B; captured with start
busy  out  1  compare in progress
done  out  1  one-cycle pulse: result flags valid and updated
equals  out  1  A == B
greater  out  1  A > B
lesser  out  1  A < B

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Outputs are registered.
- Reset values: busy=0, done=0, equals=0, greater=0, lesser=0. Internal state is IDLE; operand registers are 0.
- State machine: IDLE and CMP.
- IDLE:
  - start=1 at an edge captures a, b and signed_mode.
  - In signed mode, the MSB of both captured operands is inverted (offset-binary). The remaining compare is then unsigned.
  - Chunk index is set to 0 (the most significant chunk). busy goes 1; state goes to CMP.
- CMP, each cycle:
  - Compare the current top CHUNK bits of A and B (unsigned). Then shift both registers left by CHUNK and increment the chunk index.
  - If the chunks differ: at the next edge, set greater/lesser from that chunk, equals=0, done=1, busy=0, state to IDLE (early exit).
  - If the chunks are equal and the index is NCH-1: at the next edge, set equals=1, greater=0, lesser=0, done=1, busy=0, state to IDLE.
  - Otherwise stay in CMP.
- Latency: from the capture edge, done rises after k edges, where k is the 1-based position of the first differing chunk. k = NCH for equal operands. Range 1..NCH.
- Flag rules:
  - Flags change only on the edge that raises done. They hold until the next done.
  - After the first done, exactly one flag is 1. Before the first done (and after reset), all three are 0.
- done is high for exactly one cycle.
- start while busy=1 is ignored. Operands are not recaptured and the in-flight result is unaffected.
- start in the same cycle done is high: busy is already 0, so the request is accepted. Back-to-back operations have no bubble.
- a, b and signed_mode are don't-care except on the edge where start is accepted.
- Reset mid-operation: asserting rst_n=0 immediately forces all outputs to reset values and aborts the operation. No done is produced for the aborted compare.
- CHUNK = WIDTH degenerates to a fixed 1-cycle registered comparator. This is legal.

Decomposition:
- Shared package cmp_pkg:
  - state typedef {IDLE, CMP};
  - result encoding constants RES_EQ, RES_GT, RES_LT;
  - helper function for the signed-mode MSB inversion.
- One sub-module, cmp_chunk (parameter CHUNK). Purely combinational: inputs ca, cb; outputs gt, lt.
- The top-level holds the FSM, shift registers, chunk counter and output registers.

Test Plan (WIDTH=8, CHUNK=2 unless stated):
- a=0x42, b=0xC2, signed_mode=0 → lesser=1, equals=0, greater=0; done exactly 1 cycle after the capture edge (MS chunk 01<11).
- a=0x5A, b=0x5A, unsigned → equals=1; done 4 cycles after capture; busy high for those 4 cycles.
- a=0x10, b=0x11 → lesser=1 after 4 cycles. Then, in the done cycle, start with a=0x11, b=0x10 → greater=1 after 4 more cycles, no gap.
- a=0xFE, b=0x01: signed_mode=1 → lesser=1 after 1 cycle; signed_mode=0 → greater=1 after 1 cycle.
- Start a=0x00, b=0x01. Pulse start again with a=0xFF, b=0x00 while busy → second request ignored; result lesser=1 after 4 cycles. Repeat with rst_n pulsed low mid-operation → all outputs 0 immediately, no done.
- WIDTH=3, CHUNK=1: a=3'b010, b=3'b110 → lesser after 1 cycle. Then a=3'b110, b=3'b010 → greater after 1 cycle.

Source files
------------

// File: rtl/seq_mag_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   state_t    : controller states (IDLE, CMP)
//   RES_*      : 2-bit result encoding for one chunk compare
//   msb_fix    : MSB adjustment mapping two's-complement onto offset-binary
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;

  // Inverting the sign bit turns a signed compare into an unsigned one.
  function automatic logic msb_fix(input logic msb, input logic signed_mode);
    return msb ^ signed_mode;
  endfunction

endpackage

// File: rtl/seq_mag_cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
//   ca, cb : slice operands
//   gt     : ca > cb
//   lt     : ca < cb
module cmp_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] ca,
  input  logic [CHUNK-1:0] cb,
  output logic             gt,
  output logic             lt
);

  always_comb begin
    gt = (ca > cb);
    lt = (ca < cb);
  end

endmodule

// File: rtl/seq_mag_cmp.sv
// Registered magnitude comparator, MSB-first, CHUNK bits per clock with
// early exit on the first differing chunk. Signed or unsigned per request.
//   clk, rst_n          : clock, async active-low reset
//   start               : request (ignored while busy)
//   signed_mode, a, b   : captured on the accepting edge
//   busy                : compare in progress
//   done                : one-cycle pulse, flags updated
//   equals/greater/lesser : result flags, held until next done
module seq_mag_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equals,
  output logic             greater,
  output logic             lesser
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sa_nxt, sb_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic             busy_nxt, done_nxt, eq_nxt, gt_nxt, lt_nxt;
  logic             c_gt, c_lt;
  logic [1:0]       res;

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .ca (sa[WIDTH-1 -: CHUNK]),
    .cb (sb[WIDTH-1 -: CHUNK]),
    .gt (c_gt),
    .lt (c_lt)
  );

  always_comb begin
    if (c_gt)      res = RES_GT;
    else if (c_lt) res = RES_LT;
    else           res = RES_EQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      equals  <= 1'b0;
      greater <= 1'b0;
      lesser  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sa      <= sa_nxt;
      sb      <= sb_nxt;
      idx     <= idx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      equals  <= eq_nxt;
      greater <= gt_nxt;
      lesser  <= lt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sa_nxt    = sa;
    sb_nxt    = sb;
    idx_nxt   = idx;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    eq_nxt    = equals;
    gt_nxt    = greater;
    lt_nxt    = lesser;
    unique case (state)
      IDLE: begin
        if (start) begin
          sa_nxt    = {msb_fix(a[WIDTH-1], signed_mode), a[WIDTH-2:0]};
          sb_nxt    = {msb_fix(b[WIDTH-1], signed_mode), b[WIDTH-2:0]};
          idx_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        sa_nxt  = sa << CHUNK;
        sb_nxt  = sb << CHUNK;
        idx_nxt = idx + IW'(1);
        if (res != RES_EQ || idx == LAST) begin
          eq_nxt    = (res == RES_EQ);
          gt_nxt    = (res == RES_GT);
          lt_nxt    = (res == RES_LT);
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Directed, table-driven bench for seq_mag_cmp (8/2 and 3/1 instances).
module tb_seq_mag_cmp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, sm8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, eq8, gt8, lt8;

  logic       start3 = 1'b0, sm3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, eq3, gt3, lt3;

  seq_mag_cmp #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .equals(eq8), .greater(gt8), .lesser(lt8)
  );

  seq_mag_cmp #(.WIDTH(3), .CHUNK(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .signed_mode(sm3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .equals(eq3), .greater(gt3), .lesser(lt3)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // exp = {equals, greater, lesser}
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    bit         chain;
    logic [2:0] exp;
    int         lat;
  } vec_t;

  // Launch one compare and wait (bounded) for done; leaves time at #1 after
  // the done edge so a chained request can be issued in the done cycle.
  task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input bit chain, output int lat, output bit busy_ok);
    if (!chain) @(negedge clk);
    if (sel) begin a3 = a[2:0]; b3 = b[2:0]; sm3 = sm; start3 = 1'b1; end
    else     begin a8 = a;      b8 = b;      sm8 = sm; start8 = 1'b1; end
    @(posedge clk); #1;
    start3 = 1'b0; start8 = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!(sel ? done3 : done8) && lat <= 20) begin
      if (!(sel ? busy3 : busy8)) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t v[10];
  int   lat;
  bit   bok;
  bit   saw_done;

  initial begin
    v[0] = '{8'h42, 8'hC2, 1'b0, 1'b0, 3'b001, 1};
    v[1] = '{8'h5A, 8'h5A, 1'b0, 1'b0, 3'b100, 4};
    v[2] = '{8'h10, 8'h11, 1'b0, 1'b0, 3'b001, 4};
    v[3] = '{8'h11, 8'h10, 1'b0, 1'b1, 3'b010, 4};
    v[4] = '{8'hFE, 8'h01, 1'b1, 1'b0, 3'b001, 1};
    v[5] = '{8'hFE, 8'h01, 1'b0, 1'b0, 3'b010, 1};
    v[6] = '{8'h80, 8'h7F, 1'b1, 1'b0, 3'b001, 1};
    v[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 3'b100, 4};
    v[8] = '{8'h34, 8'h38, 1'b0, 1'b0, 3'b001, 3};
    v[9] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 3'b010, 4};

    #1;
    chk("reset_outputs8", {busy8, done8, eq8, gt8, lt8}, 5'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_outputs8", {busy8, done8, eq8, gt8, lt8}, 5'b0);

    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, v[i].a, v[i].b, v[i].sm, v[i].chain, lat, bok);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_busy_during", i), bok, 1'b1);
      chk($sformatf("v%0d_flags", i), {eq8, gt8, lt8}, v[i].exp);
      chk($sformatf("v%0d_busy_at_done", i), busy8, 1'b0);
      if (i + 1 < 10 && v[i+1].chain) continue;
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), done8, 1'b0);
      chk($sformatf("v%0d_flags_held", i), {eq8, gt8, lt8}, v[i].exp);
    end

    // start while busy must be ignored
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h01; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat <= 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_start_latency", lat, 4);
    chk("busy_start_flags", {eq8, gt8, lt8}, 3'b001);

    // reset mid-operation
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #2;
    chk("pre_reset_busy", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {busy8, done8, eq8, gt8, lt8}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    chk("aborted_no_done", saw_done, 1'b0);
    chk("aborted_flags", {eq8, gt8, lt8}, 3'b000);

    run_op(1'b0, 8'h42, 8'hC2, 1'b0, 1'b0, lat, bok);
    chk("post_reset_latency", lat, 1);
    chk("post_reset_flags", {eq8, gt8, lt8}, 3'b001);

    // 3-bit, 1-bit chunks
    run_op(1'b1, 8'h02, 8'h06, 1'b0, 1'b0, lat, bok);
    chk("w3_lt_latency", lat, 1);
    chk("w3_lt_flags", {eq3, gt3, lt3}, 3'b001);
    run_op(1'b1, 8'h06, 8'h02, 1'b0, 1'b0, lat, bok);
    chk("w3_gt_latency", lat, 1);
    chk("w3_gt_flags", {eq3, gt3, lt3}, 3'b010);
    run_op(1'b1, 8'h05, 8'h05, 1'b0, 1'b0, lat, bok);
    chk("w3_eq_latency", lat, 3);
    chk("w3_eq_flags", {eq3, gt3, lt3}, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
